// File: rtl/bomber_gfx_pkg.sv
// Shared graphics types for the bomber game: screen geometry, coordinates,
// colours, rectangle commands and the draw-arbiter state encoding.
package bomber_gfx_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    typedef logic [9:0] xcoord_t;
    typedef logic [8:0] ycoord_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t COL_BRICK = '{r: 8'd77, g: 8'd79, b: 8'd76};
    localparam rgb_t COL_GRASS = '{r: 8'd36, g: 8'd104, b: 8'd3};

    typedef struct packed {
        xcoord_t x0;
        ycoord_t y0;
        xcoord_t w;
        ycoord_t h;
        rgb_t    rgb;
    } rect_cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } draw_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request searching upward
// (with wrap) from last_grant_i+1. The pointer register lives in the caller.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IdxW-1:0]    last_grant_i,
    output logic [NUM_REQ-1:0] grant_o
);

    localparam int unsigned      PtrW   = IdxW + 1;
    localparam logic [PtrW-1:0]  NumReq = PtrW'(NUM_REQ);

    logic            found;
    logic [PtrW-1:0] ptr;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        ptr     = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            ptr = {1'b0, last_grant_i} + PtrW'(i);
            if (ptr >= NumReq) begin
                ptr = ptr - NumReq;
            end
            if (!found && req_i[ptr[IdxW-1:0]]) begin
                grant_o[ptr[IdxW-1:0]] = 1'b1;
                found                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/draw_arbiter.sv
// Round-robin rectangle-fill arbiter feeding the framebuffer pixel-write port.
// Define DRAW_CLIP_EN to clip rectangles to the screen at command capture.
module draw_arbiter #(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*10-1:0] req_x0,
    input  logic [NUM_REQ*9-1:0]  req_y0,
    input  logic [NUM_REQ*10-1:0] req_w,
    input  logic [NUM_REQ*9-1:0]  req_h,
    input  logic [NUM_REQ*24-1:0] req_rgb,
    output logic [NUM_REQ-1:0]    req_done,
    output logic                  fb_we,
    input  logic                  fb_ready,
    output logic [9:0]            fb_x,
    output logic [8:0]            fb_y,
    output logic [7:0]            fb_r,
    output logic [7:0]            fb_g,
    output logic [7:0]            fb_b,
    output logic                  busy
);

    import bomber_gfx_pkg::xcoord_t;
    import bomber_gfx_pkg::ycoord_t;
    import bomber_gfx_pkg::rgb_t;
    import bomber_gfx_pkg::rect_cmd_t;
    import bomber_gfx_pkg::draw_state_t;
    import bomber_gfx_pkg::IDLE;
    import bomber_gfx_pkg::DRAW;
    import bomber_gfx_pkg::DONE;

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (SCREEN_W > 1024 || SCREEN_H > 512) begin : g_bad_screen
        $error("draw_arbiter: screen size exceeds coordinate width");
    end

    draw_state_t     state_q, state_d;
    logic [IdxW-1:0] last_grant_q, last_grant_d;
    logic [IdxW-1:0] grant_idx_q, grant_idx_d;
    xcoord_t         x0_q, x0_d;
    rgb_t            rgb_q, rgb_d;
    // Scan position and end points are one bit wider so x0+w / y0+h never wrap.
    logic [10:0]     cur_x_q, cur_x_d, x_last_q, x_last_d;
    logic [9:0]      cur_y_q, cur_y_d, y_last_q, y_last_d;

    logic [NUM_REQ-1:0] grant;
    logic [IdxW-1:0]    win_idx;
    rect_cmd_t          sel_cmd;
    xcoord_t            clip_w;
    ycoord_t            clip_h;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IdxW    (IdxW)
    ) u_rr_arbiter (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    always_comb begin
        sel_cmd = '0;
        win_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_idx     = IdxW'(i);
                sel_cmd.x0  = req_x0[i*10 +: 10];
                sel_cmd.y0  = req_y0[i*9 +: 9];
                sel_cmd.w   = req_w[i*10 +: 10];
                sel_cmd.h   = req_h[i*9 +: 9];
                sel_cmd.rgb = req_rgb[i*24 +: 24];
            end
        end
    end

`ifdef DRAW_CLIP_EN
    localparam logic [10:0] ScrW = 11'(SCREEN_W);
    localparam logic [9:0]  ScrH = 10'(SCREEN_H);

    always_comb begin
        clip_w = sel_cmd.w;
        clip_h = sel_cmd.h;
        if ({1'b0, sel_cmd.x0} >= ScrW) begin
            clip_w = '0;
        end else if ({1'b0, sel_cmd.w} > ScrW - {1'b0, sel_cmd.x0}) begin
            clip_w = 10'(ScrW - {1'b0, sel_cmd.x0});
        end
        if ({1'b0, sel_cmd.y0} >= ScrH) begin
            clip_h = '0;
        end else if ({1'b0, sel_cmd.h} > ScrH - {1'b0, sel_cmd.y0}) begin
            clip_h = 9'(ScrH - {1'b0, sel_cmd.y0});
        end
    end
`else
    always_comb begin
        clip_w = sel_cmd.w;
        clip_h = sel_cmd.h;
    end
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_idx_d  = grant_idx_q;
        x0_d         = x0_q;
        rgb_d        = rgb_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        x_last_d     = x_last_q;
        y_last_d     = y_last_q;
        unique case (state_q)
            IDLE: begin
                if (|grant) begin
                    grant_idx_d = win_idx;
                    x0_d        = sel_cmd.x0;
                    rgb_d       = sel_cmd.rgb;
                    cur_x_d     = {1'b0, sel_cmd.x0};
                    cur_y_d     = {1'b0, sel_cmd.y0};
                    x_last_d    = {1'b0, sel_cmd.x0} + {1'b0, clip_w} - 11'd1;
                    y_last_d    = {1'b0, sel_cmd.y0} + {1'b0, clip_h} - 10'd1;
                    state_d     = (clip_w == '0 || clip_h == '0) ? DONE : DRAW;
                end
            end
            DRAW: begin
                if (fb_ready) begin
                    if (cur_x_q == x_last_q) begin
                        cur_x_d = {1'b0, x0_q};
                        if (cur_y_q == y_last_q) begin
                            state_d = DONE;
                        end else begin
                            cur_y_d = cur_y_q + 10'd1;
                        end
                    end else begin
                        cur_x_d = cur_x_q + 11'd1;
                    end
                end
            end
            DONE: begin
                last_grant_d = grant_idx_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            last_grant_q <= IdxW'(NUM_REQ - 1);
            grant_idx_q  <= '0;
            x0_q         <= '0;
            rgb_q        <= '0;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            x_last_q     <= '0;
            y_last_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_idx_q  <= grant_idx_d;
            x0_q         <= x0_d;
            rgb_q        <= rgb_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            x_last_q     <= x_last_d;
            y_last_q     <= y_last_d;
        end
    end

    // Accept is combinational; gate with reset so the port reads 0 while held.
    always_comb begin
        req_ready = (state_q == IDLE && RESET_N) ? grant : '0;
        req_done  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_done[i] = (state_q == DONE) && (grant_idx_q == IdxW'(i));
        end
        fb_we = (state_q == DRAW);
        busy  = (state_q != IDLE);
        fb_x  = fb_we ? cur_x_q[9:0] : '0;
        fb_y  = fb_we ? cur_y_q[8:0] : '0;
        fb_r  = fb_we ? rgb_q.r : '0;
        fb_g  = fb_we ? rgb_q.g : '0;
        fb_b  = fb_we ? rgb_q.b : '0;
    end

endmodule

// File: tb/tb_draw_arbiter.sv
// Scoreboard bench for draw_arbiter: stimulus pushes expected grants, pixels and
// done pulses; a negedge monitor pops and compares whatever the DUT presents.
module tb_draw_arbiter;
    import bomber_gfx_pkg::*;

    localparam int NR = 3;

    typedef struct {
        int   x;
        int   y;
        rgb_t c;
        int   rel;
    } pix_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*10-1:0] req_x0;
    logic [NR*9-1:0] req_y0;
    logic [NR*10-1:0] req_w;
    logic [NR*9-1:0] req_h;
    logic [NR*24-1:0] req_rgb;
    logic [NR-1:0]   req_done;
    logic            fb_we;
    logic            fb_ready;
    logic [9:0]      fb_x;
    logic [8:0]      fb_y;
    logic [7:0]      fb_r, fb_g, fb_b;
    logic            busy;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_done = 0;
    int   exp_done = 0;
    int   t_acc = 0;
    int   t_last = 0;
    int   npix = 0;
    bit   stall_prev = 1'b0;
    logic [42:0] stall_val;

    pix_t pix_q[$];
    int   gnt_q[$];
    int   done_q[$];
    bit   rdy_pat[$];

    draw_arbiter #(
        .NUM_REQ  (NR),
        .SCREEN_W (640),
        .SCREEN_H (480)
    ) dut (
        .CLOCK_50  (clk),
        .RESET_N   (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x0    (req_x0),
        .req_y0    (req_y0),
        .req_w     (req_w),
        .req_h     (req_h),
        .req_rgb   (req_rgb),
        .req_done  (req_done),
        .fb_we     (fb_we),
        .fb_ready  (fb_ready),
        .fb_x      (fb_x),
        .fb_y      (fb_y),
        .fb_r      (fb_r),
        .fb_g      (fb_g),
        .fb_b      (fb_b),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // fb_ready driver: follows a queued pattern while a pixel is offered, else 1.
    initial begin
        fb_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (fb_we && rdy_pat.size() != 0) fb_ready = rdy_pat.pop_front();
            else fb_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (req_ready != '0) begin
                chk("ready_while_busy", 64'(busy), 64'd0);
                chk("grant_expected", 64'(gnt_q.size() != 0), 64'd1);
                if (gnt_q.size() != 0) chk("grant", 64'(req_ready), 64'(1 << gnt_q.pop_front()));
                t_acc = cyc;
                npix  = 0;
            end
            if (stall_prev) chk("stall_hold", {20'(fb_we), fb_x, fb_y, fb_r, fb_g, fb_b},
                                {20'd1, stall_val});
            if (fb_we && fb_ready) begin
                chk("pix_expected", 64'(pix_q.size() != 0), 64'd1);
                if (pix_q.size() != 0) begin
                    pix_t e;
                    e = pix_q.pop_front();
                    chk("pixel", {fb_x, fb_y, fb_r, fb_g, fb_b}, {10'(e.x), 9'(e.y), e.c});
                    if (e.rel >= 0) chk("pixel_time", 64'(cyc - t_acc), 64'(e.rel));
                end
                npix++;
                t_last = cyc;
            end
            stall_prev = fb_we && !fb_ready;
            stall_val  = {fb_x, fb_y, fb_r, fb_g, fb_b};
            if (req_done != '0) begin
                chk("done_expected", 64'(done_q.size() != 0), 64'd1);
                if (done_q.size() != 0) chk("done_id", 64'(req_done), 64'(1 << done_q.pop_front()));
                chk("done_time", 64'(cyc), 64'(npix > 0 ? t_last + 1 : t_acc + 1));
                n_done++;
            end
        end
    end

    task automatic set_cmd(input int r, input int x0, input int y0, input int w, input int h,
                           input rgb_t c);
        req_x0[r*10 +: 10] = 10'(x0);
        req_y0[r*9 +: 9]   = 9'(y0);
        req_w[r*10 +: 10]  = 10'(w);
        req_h[r*9 +: 9]    = 9'(h);
        req_rgb[r*24 +: 24] = c;
    endtask

    task automatic push_rect(input int x0, input int y0, input int w, input int h,
                             input rgb_t c, input int rel0);
        int k;
        k = 0;
        for (int y = y0; y < y0 + h; y++) begin
            for (int x = x0; x < x0 + w; x++) begin
                pix_q.push_back('{x: x, y: y, c: c, rel: (rel0 < 0) ? -1 : rel0 + k});
                k++;
            end
        end
    endtask

    // Raise valid for requester r, wait for its accept, then drop valid.
    task automatic issue(input int r);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1 req_valid[r] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready[r]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_timeout", 64'(ok), 64'd1);
        @(posedge clk);
        #1 req_valid[r] = 1'b0;
    endtask

    task automatic wait_done(input int target);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            if (n_done >= target) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_timeout", 64'(ok), 64'd1);
        #1 chk("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic single(input int r, input int x0, input int y0, input int w, input int h,
                          input rgb_t c, input int rel0);
        set_cmd(r, x0, y0, w, h, c);
        gnt_q.push_back(r);
        done_q.push_back(r);
        exp_done++;
        issue(r);
        wait_done(exp_done);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rgb_t c2;
        c2 = 24'h123456;
        rst_n     = 1'b0;
        req_valid = '0;
        req_x0 = '0; req_y0 = '0; req_w = '0; req_h = '0; req_rgb = '0;

        // Reset state; all three requesters already valid with 1x1 commands.
        set_cmd(0, 0, 0, 1, 1, COL_BRICK);
        set_cmd(1, 1, 1, 1, 1, COL_GRASS);
        set_cmd(2, 2, 2, 1, 1, c2);
        req_valid = 3'b111;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_fb_we", 64'(fb_we), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_done", 64'(req_done), 64'd0);
        chk("rst_fb_xy", {fb_x, fb_y}, 64'd0);

        // Round robin 0,1,2,0,1 then req1 drops: 2,0.
        foreach (gnt_q[i]) ;
        begin
            int order[7] = '{0, 1, 2, 0, 1, 2, 0};
            for (int i = 0; i < 7; i++) begin
                gnt_q.push_back(order[i]);
                done_q.push_back(order[i]);
                case (order[i])
                    0: push_rect(0, 0, 1, 1, COL_BRICK, -1);
                    1: push_rect(1, 1, 1, 1, COL_GRASS, -1);
                    default: push_rect(2, 2, 1, 1, c2, -1);
                endcase
            end
        end
        rst_n = 1'b1;
        exp_done += 5;
        wait_done(exp_done);
        req_valid = 3'b101;
        exp_done += 2;
        wait_done(exp_done);
        req_valid = '0;
        repeat (2) @(posedge clk);

        // 2x2 grass at (10,20), fb_ready always 1: pixels at T+1..T+4.
        push_rect(10, 20, 2, 2, COL_GRASS, 1);
        single(0, 10, 20, 2, 2, COL_GRASS, 1);

        // Same command under backpressure.
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        push_rect(10, 20, 2, 2, COL_GRASS, -1);
        single(0, 10, 20, 2, 2, COL_GRASS, -1);

        // Zero-size commands.
        single(1, 5, 5, 0, 5, COL_BRICK, -1);
        single(1, 5, 5, 5, 0, COL_BRICK, -1);

        // Right-edge rectangle and off-screen start.
`ifdef DRAW_CLIP_EN
        push_rect(630, 0, 10, 2, COL_BRICK, -1);
`else
        push_rect(630, 0, 20, 2, COL_BRICK, -1);
`endif
        single(2, 630, 0, 20, 2, COL_BRICK, -1);
`ifndef DRAW_CLIP_EN
        push_rect(700, 0, 4, 1, c2, -1);
`endif
        single(2, 700, 0, 4, 1, c2, -1);

        // Asynchronous reset during the 3rd pixel of a 4x4 draw.
        set_cmd(2, 100, 50, 4, 4, c2);
        gnt_q.push_back(2);
        push_rect(100, 50, 2, 1, c2, 1);
        issue(2);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_fb_we", 64'(fb_we), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(req_done), 64'd0);
        chk("arst_pix_seen", 64'(pix_q.size()), 64'd0);
        pix_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        set_cmd(0, 3, 4, 1, 1, COL_GRASS);
        set_cmd(1, 7, 8, 1, 1, COL_BRICK);
        gnt_q.push_back(0);
        gnt_q.push_back(1);
        done_q.push_back(0);
        done_q.push_back(1);
        push_rect(3, 4, 1, 1, COL_GRASS, 1);
        push_rect(7, 8, 1, 1, COL_BRICK, 1);
        @(posedge clk);
        #1 req_valid = 3'b011;
        exp_done += 2;
        wait_done(exp_done);
        req_valid = '0;
        repeat (3) @(posedge clk);

        chk("pix_left", 64'(pix_q.size()), 64'd0);
        chk("grant_left", 64'(gnt_q.size()), 64'd0);
        chk("done_left", 64'(done_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
